// File: rtl/cruise_control_fsm.sv
// Cruise-control sequencer: engages on request, paces periodic speed compares through the datapath,
// serves setpoint button requests and drives registered throttle demands.
module cruise_control_fsm #(
    parameter int unsigned STEP_PERIOD = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cruise_on,
    input  logic       cruise_off,
    input  logic       brake,
    input  logic       set_plus,
    input  logic       set_minus,
    input  logic       gt,
    input  logic       eq,
    input  logic       lt,
    output logic [1:0] s,
    output logic       active,
    output logic       throttle_up,
    output logic       throttle_down,
    output logic       fault
);

    typedef enum logic [2:0] {
        StOff,
        StLoad,
        StHold,
        StCmp,
        StEval,
        StInc,
        StDec
    } state_e;

    localparam logic [7:0] Reload = 8'(STEP_PERIOD - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pend_plus_q, pend_plus_d;
    logic       pend_minus_q, pend_minus_d;
    logic       plus_prev_q, minus_prev_q;
    logic       plus_edge, minus_edge;
    logic       flags_ok;
    logic       up_d, down_d, fault_d;
    logic [1:0] s_d;

    assign plus_edge  = set_plus & ~plus_prev_q;
    assign minus_edge = set_minus & ~minus_prev_q;
    assign flags_ok   = $onehot({gt, eq, lt});

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_plus_d  = pend_plus_q;
        pend_minus_d = pend_minus_q;
        up_d         = throttle_up;
        down_d       = throttle_down;
        fault_d      = fault;

        unique case (state_q)
            StOff: begin
                if (cruise_on && !brake && !cruise_off) state_d = StLoad;
            end
            StLoad: begin
                state_d = StHold;
                cnt_d   = Reload;
            end
            StHold: begin
                // Button requests pre-empt expiry and leave the step counter frozen.
                if (pend_plus_q) begin
                    state_d = StInc;
                end else if (pend_minus_q) begin
                    state_d = StDec;
                end else if (cnt_q == 8'd0) begin
                    state_d = StCmp;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StCmp: state_d = StEval;
            StEval: begin
                state_d = StHold;
                cnt_d   = Reload;
                up_d    = lt & flags_ok;
                down_d  = gt & flags_ok;
                if (!flags_ok) fault_d = 1'b1;
            end
            StInc: begin
                state_d     = StHold;
                pend_plus_d = 1'b0;
            end
            StDec: begin
                state_d      = StHold;
                pend_minus_d = 1'b0;
            end
            default: state_d = StOff;
        endcase

        if (state_q != StOff) begin
            if (plus_edge) pend_plus_d = 1'b1;
            if (minus_edge) pend_minus_d = 1'b1;
            if (brake || cruise_off) state_d = StOff;
        end

        // Contradictory requests cancel each other.
        if ((plus_edge && minus_edge) || (pend_plus_d && pend_minus_d)) begin
            pend_plus_d  = 1'b0;
            pend_minus_d = 1'b0;
        end

        if (state_d == StOff) begin
            pend_plus_d  = 1'b0;
            pend_minus_d = 1'b0;
            up_d         = 1'b0;
            down_d       = 1'b0;
            cnt_d        = 8'd0;
        end

        unique case (state_d)
            StCmp:   s_d = 2'b01;
            StInc:   s_d = 2'b10;
            StDec:   s_d = 2'b11;
            default: s_d = 2'b00;
        endcase
    end

    // Outputs are registered from the next state so they align with the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StOff;
            cnt_q         <= 8'd0;
            pend_plus_q   <= 1'b0;
            pend_minus_q  <= 1'b0;
            plus_prev_q   <= 1'b0;
            minus_prev_q  <= 1'b0;
            s             <= 2'b00;
            active        <= 1'b0;
            throttle_up   <= 1'b0;
            throttle_down <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pend_plus_q   <= pend_plus_d;
            pend_minus_q  <= pend_minus_d;
            plus_prev_q   <= set_plus;
            minus_prev_q  <= set_minus;
            s             <= s_d;
            active        <= (state_d != StOff);
            throttle_up   <= up_d;
            throttle_down <= down_d;
            fault         <= fault_d;
        end
    end

endmodule

// File: tb/tb_cruise_control_fsm.sv
// Directed self-checking bench for cruise_control_fsm with STEP_PERIOD = 4.
module tb_cruise_control_fsm;

    logic       clock = 1'b0;
    logic       reset, cruise_on, cruise_off, brake, set_plus, set_minus, gt, eq, lt;
    logic [1:0] s;
    logic       active, throttle_up, throttle_down, fault;
    int         checks = 0;
    int         errors = 0;

    cruise_control_fsm #(.STEP_PERIOD(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .cruise_on    (cruise_on),
        .cruise_off   (cruise_off),
        .brake        (brake),
        .set_plus     (set_plus),
        .set_minus    (set_minus),
        .gt           (gt),
        .eq           (eq),
        .lt           (lt),
        .s            (s),
        .active       (active),
        .throttle_up  (throttle_up),
        .throttle_down(throttle_down),
        .fault        (fault)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        reset = 0; cruise_on = 0; cruise_off = 0; brake = 0;
        set_plus = 0; set_minus = 0; gt = 0; eq = 0; lt = 0;
    endtask

    // Leaves the DUT in LOAD (cycle 1 after engage).
    task automatic engage();
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
        cruise_on = 1;
        tick();
        cruise_on = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1; cruise_on = 1; lt = 1;
        tick();
        tick();
        checks++; if (s !== 2'b00) begin errors++; $display("FAIL reset_s got %0d want 0", s); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %0b want 0", active); end
        checks++; if (throttle_up !== 1'b0 || throttle_down !== 1'b0) begin
            errors++; $display("FAIL reset_throttle got %0b%0b want 00", throttle_up, throttle_down); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0b want 0", fault); end
        clear_inputs();
    endtask

    task automatic test_engage_timing();
        engage();
        checks++; if (active !== 1'b1 || s !== 2'b00) begin
            errors++; $display("FAIL load_state got active=%0b s=%0d want 1 0", active, s); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (s !== 2'b00 || active !== 1'b1) begin
                errors++; $display("FAIL hold_%0d got s=%0d active=%0b want 0 1", i, s, active); end
        end
        tick();
        checks++; if (s !== 2'b01) begin errors++; $display("FAIL cmp_cycle6 got %0d want 1", s); end
    endtask

    task automatic test_throttle_track();
        engage();
        lt = 1;
        repeat (5) tick();
        tick();
        checks++; if (throttle_up !== 1'b0) begin errors++; $display("FAIL eval_up_early got %0b want 0", throttle_up); end
        tick();
        checks++; if (throttle_up !== 1'b1 || throttle_down !== 1'b0) begin
            errors++; $display("FAIL lt_throttle got %0b%0b want 10", throttle_up, throttle_down); end
        lt = 0; eq = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (throttle_up !== 1'b1) begin
                errors++; $display("FAIL up_held_%0d got %0b want 1", i, throttle_up); end
        end
        tick();
        checks++; if (s !== 2'b01 || throttle_up !== 1'b1) begin
            errors++; $display("FAIL second_cmp got s=%0d up=%0b want 1 1", s, throttle_up); end
        tick();
        tick();
        checks++; if (throttle_up !== 1'b0 || throttle_down !== 1'b0) begin
            errors++; $display("FAIL eq_throttle got %0b%0b want 00", throttle_up, throttle_down); end
    endtask

    task automatic test_gt();
        engage();
        gt = 1;
        repeat (7) tick();
        checks++; if (throttle_down !== 1'b1 || throttle_up !== 1'b0) begin
            errors++; $display("FAIL gt_throttle got up=%0b down=%0b want 0 1", throttle_up, throttle_down); end
    endtask

    task automatic test_set_plus_held();
        int n_inc;
        engage();
        tick();
        set_plus = 1;
        tick();
        checks++; if (s !== 2'b00) begin errors++; $display("FAIL plus_pend_s got %0d want 0", s); end
        tick();
        checks++; if (s !== 2'b10) begin errors++; $display("FAIL plus_inc_s got %0d want 2", s); end
        tick();
        checks++; if (s !== 2'b00) begin errors++; $display("FAIL plus_after_s got %0d want 0", s); end
        n_inc = 0;
        repeat (7) begin
            tick();
            if (s === 2'b10) n_inc++;
        end
        checks++; if (n_inc !== 0) begin errors++; $display("FAIL plus_held_extra got %0d want 0", n_inc); end
        set_plus = 0;
    endtask

    task automatic test_set_minus();
        engage();
        tick();
        set_minus = 1;
        tick();
        set_minus = 0;
        tick();
        checks++; if (s !== 2'b11) begin errors++; $display("FAIL minus_dec_s got %0d want 3", s); end
        tick();
        checks++; if (s !== 2'b00) begin errors++; $display("FAIL minus_after_s got %0d want 0", s); end
    endtask

    task automatic test_set_plus_in_cmp();
        engage();
        eq = 1;
        repeat (5) tick();
        checks++; if (s !== 2'b01) begin errors++; $display("FAIL cmp_plus_s got %0d want 1", s); end
        set_plus = 1;
        tick();
        set_plus = 0;
        checks++; if (s !== 2'b00) begin errors++; $display("FAIL eval_plus_s got %0d want 0", s); end
        tick();
        tick();
        checks++; if (s !== 2'b10) begin errors++; $display("FAIL cmp_plus_inc got %0d want 2", s); end
    endtask

    task automatic test_cancel();
        int n_step;
        engage();
        tick();
        set_plus = 1; set_minus = 1;
        n_step = 0;
        repeat (8) begin
            tick();
            if (s[1] === 1'b1) n_step++;
        end
        checks++; if (n_step !== 0) begin errors++; $display("FAIL cancel_both got %0d want 0", n_step); end
        set_plus = 0; set_minus = 0;
    endtask

    task automatic test_off_edges();
        int n_inc;
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
        set_plus = 1;
        tick();
        cruise_on = 1;
        tick();
        cruise_on = 0;
        n_inc = 0;
        repeat (8) begin
            tick();
            if (s === 2'b10) n_inc++;
        end
        checks++; if (n_inc !== 0) begin errors++; $display("FAIL off_edge_kept got %0d want 0", n_inc); end
        set_plus = 0;
    endtask

    task automatic test_ignore_cruise_on();
        engage();
        cruise_on = 1;
        repeat (5) tick();
        checks++; if (s !== 2'b01) begin errors++; $display("FAIL cruise_on_restart got %0d want 1", s); end
        cruise_on = 0;
    endtask

    task automatic test_brake();
        engage();
        tick();
        set_plus = 1;
        tick();
        tick();
        set_plus = 0;
        checks++; if (s !== 2'b10) begin errors++; $display("FAIL brake_pre_inc got %0d want 2", s); end
        brake = 1;
        tick();
        brake = 0;
        checks++; if (active !== 1'b0 || s !== 2'b00) begin
            errors++; $display("FAIL brake_inc got active=%0b s=%0d want 0 0", active, s); end
        engage();
        lt = 1;
        repeat (6) tick();
        brake = 1;
        tick();
        checks++; if (active !== 1'b0 || throttle_up !== 1'b0 || throttle_down !== 1'b0) begin
            errors++; $display("FAIL brake_eval got active=%0b up=%0b down=%0b want 0 0 0",
                               active, throttle_up, throttle_down); end
        cruise_on = 1;
        tick();
        tick();
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL brake_on_both got %0b want 0", active); end
        clear_inputs();
    endtask

    task automatic test_cruise_off();
        engage();
        lt = 1;
        repeat (8) tick();
        checks++; if (throttle_up !== 1'b1) begin errors++; $display("FAIL off_pre_up got %0b want 1", throttle_up); end
        cruise_off = 1;
        tick();
        cruise_off = 0;
        checks++; if (active !== 1'b0 || throttle_up !== 1'b0) begin
            errors++; $display("FAIL cruise_off got active=%0b up=%0b want 0 0", active, throttle_up); end
    endtask

    task automatic test_reset_mid_cmp();
        engage();
        lt = 1;
        repeat (5) tick();
        reset = 1;
        tick();
        reset = 0;
        checks++; if (active !== 1'b0 || s !== 2'b00) begin
            errors++; $display("FAIL reset_cmp got active=%0b s=%0d want 0 0", active, s); end
        tick();
        checks++; if (throttle_up !== 1'b0) begin errors++; $display("FAIL reset_no_eval got %0b want 0", throttle_up); end
        clear_inputs();
    endtask

    task automatic test_fault();
        engage();
        gt = 1; lt = 1;
        repeat (7) tick();
        checks++; if (fault !== 1'b1 || throttle_up !== 1'b0 || throttle_down !== 1'b0) begin
            errors++; $display("FAIL fault_set got fault=%0b up=%0b down=%0b want 1 0 0",
                               fault, throttle_up, throttle_down); end
        gt = 0; lt = 0;
        cruise_off = 1;
        tick();
        cruise_off = 0;
        checks++; if (active !== 1'b0 || fault !== 1'b1) begin
            errors++; $display("FAIL fault_off got active=%0b fault=%0b want 0 1", active, fault); end
        cruise_on = 1;
        tick();
        cruise_on = 0;
        checks++; if (active !== 1'b1 || fault !== 1'b1) begin
            errors++; $display("FAIL fault_reengage got active=%0b fault=%0b want 1 1", active, fault); end
        reset = 1;
        tick();
        reset = 0;
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_reset got %0b want 0", fault); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_engage_timing();
        test_throttle_track();
        test_gt();
        test_set_plus_held();
        test_set_minus();
        test_set_plus_in_cmp();
        test_cancel();
        test_off_edges();
        test_ignore_cruise_on();
        test_brake();
        test_cruise_off();
        test_reset_mid_cmp();
        test_fault();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
